mdu_sequencer: RTL and testbench

//  Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.

---
 rtl/mdu_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Products and quotients are computed at the accept edge. They are held in pending
// registers and committed after a fixed latency, which keeps hazard timing simple.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (codes 7-10).
module mdu_sequencer #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] MulInit = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivInit = CntW'(DIV_CYCLES - 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic            divz_q, divz_d;
  logic            done_q, done_d;
`ifdef MDU_MADD_EN
  logic            acc_q, acc_d;
  logic            sub_q, sub_d;
`endif

  logic        legal, accept, mul_signed;
  logic [63:0] mul_a, mul_b, prod;
  logic [31:0] div_b, quo, rem;

  // Decode which codes are real operations and which multiplies are signed.
  always_comb begin
    legal      = (op >= OpMult) && (op <= OpMtlo);
    mul_signed = (op == OpMult);
`ifdef MDU_MADD_EN
    legal      = legal || ((op >= OpMadd) && (op <= OpMsubu));
    mul_signed = mul_signed || (op == OpMadd) || (op == OpMsub);
`endif
    accept     = op_valid && !cancel && (state_q == StIdle) && legal;
  end

  // Single 64-bit multiplier; the low 64 bits of an extended product are sign-correct.
  always_comb begin
    mul_a = {{32{mul_signed & src_a[31]}}, src_a};
    mul_b = {{32{mul_signed & src_b[31]}}, src_b};
    prod  = mul_a * mul_b;
  end

  // Divider; a zero divisor is replaced by 1 since its result is discarded at commit.
  always_comb begin
    div_b = (src_b == '0) ? 32'd1 : src_b;
    if (op == OpDiv) begin
      if ((src_a == 32'h8000_0000) && (src_b == '1)) begin
        quo = src_a;
        rem = '0;
      end else begin
        quo = $signed(src_a) / $signed(div_b);
        rem = $signed(src_a) % $signed(div_b);
      end
    end else begin
      quo = src_a / div_b;
      rem = src_a % div_b;
    end
  end

  // Next-state logic: accept in idle, count down while busy, commit on the last cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    divz_d    = divz_q;
    done_d    = 1'b0;
`ifdef MDU_MADD_EN
    acc_d     = acc_q;
    sub_d     = sub_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op)
            OpMult, OpMultu: begin
              {pend_hi_d, pend_lo_d} = prod;
              divz_d  = 1'b0;
              state_d = StMul;
              cnt_d   = MulInit;
`ifdef MDU_MADD_EN
              acc_d   = 1'b0;
              sub_d   = 1'b0;
`endif
            end
            OpDiv, OpDivu: begin
              pend_lo_d = quo;
              pend_hi_d = rem;
              divz_d    = (src_b == '0);
              state_d   = StDiv;
              cnt_d     = DivInit;
            end
            OpMthi: hi_d = src_a;
            OpMtlo: lo_d = src_a;
`ifdef MDU_MADD_EN
            OpMadd, OpMaddu, OpMsub, OpMsubu: begin
              {pend_hi_d, pend_lo_d} = prod;
              divz_d  = 1'b0;
              acc_d   = 1'b1;
              sub_d   = (op == OpMsub) || (op == OpMsubu);
              state_d = StMul;
              cnt_d   = MulInit;
            end
`endif
            default: ;
          endcase
        end
      end
      StMul: begin
        if (cnt_q == '0) begin
`ifdef MDU_MADD_EN
          // Accumulate against HI/LO as they stand at commit, not at issue.
          if (acc_q && sub_q) begin
            {hi_d, lo_d} = {hi_q, lo_q} - {pend_hi_q, pend_lo_q};
          end else if (acc_q) begin
            {hi_d, lo_d} = {hi_q, lo_q} + {pend_hi_q, pend_lo_q};
          end else begin
            {hi_d, lo_d} = {pend_hi_q, pend_lo_q};
          end
`else
          {hi_d, lo_d} = {pend_hi_q, pend_lo_q};
`endif
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDiv: begin
        if (cnt_q == '0) begin
          if (!divz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any in-flight op without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      divz_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q     <= 1'b0;
      sub_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      divz_q    <= divz_d;
      done_q    <= done_d;
`ifdef MDU_MADD_EN
      acc_q     <= acc_d;
      sub_q     <= sub_d;
`endif
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: cycle-level behavioural model plus directed literal checks.
module tb_mdu_sequencer;

  localparam int MulCyc = 5;
  localparam int DivCyc = 10;
  localparam int Window = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_sequencer #(
    .MUL_CYCLES(MulCyc),
    .DIV_CYCLES(DivCyc)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_rem  = 0;   // busy cycles still to come
  logic [63:0] m_res  = '0;
  bit          m_skip = 0;   // divide by zero: keep HI/LO
  bit          m_acc  = 0;
  bit          m_sub  = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  bit          m_done = 0;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  function automatic logic [63:0] umul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x, y;
    x = {32'b0, a};
    y = {32'b0, b};
    return x * y;
  endfunction

  task automatic model_accept(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    bit madd_ok;
`ifdef MDU_MADD_EN
    madd_ok = 1;
`else
    madd_ok = 0;
`endif
    m_skip = 0;
    m_acc  = 0;
    m_sub  = 0;
    case (o)
      4'd1: begin m_res = smul(a, b); m_rem = MulCyc; end
      4'd2: begin m_res = umul(a, b); m_rem = MulCyc; end
      4'd3, 4'd4: begin
        m_rem = DivCyc;
        if (b == 0) m_skip = 1;
        else begin
          x = (o == 4'd3) ? longint'($signed(a)) : longint'({32'b0, a});
          y = (o == 4'd3) ? longint'($signed(b)) : longint'({32'b0, b});
          q = x / y;
          r = x % y;
          m_res = {r[31:0], q[31:0]};
        end
      end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      4'd7, 4'd8, 4'd9, 4'd10: begin
        if (madd_ok) begin
          m_res = (o == 4'd7 || o == 4'd9) ? smul(a, b) : umul(a, b);
          m_acc = 1;
          m_sub = (o == 4'd9 || o == 4'd10);
          m_rem = MulCyc;
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_res = '0; m_skip = 0; m_acc = 0; m_sub = 0;
      m_hi = '0; m_lo = '0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_acc) {m_hi, m_lo} = m_sub ? {m_hi, m_lo} - m_res : {m_hi, m_lo} + m_res;
          else if (!m_skip) {m_hi, m_lo} = m_res;
          m_done = 1;
        end
      end else if (op_valid && !cancel) begin
        model_accept(op, src_a, src_b);
      end
    end
  end

  // Compare every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_rem > 0));
      check("done", 32'(done), 32'(m_done));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                     output int nbusy, output int ndone);
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = b; cancel = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < Window; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) ndone++;
    end
  endtask

  int nb, nd, exp_nb;
  logic [31:0] exp_hi, exp_lo;
  bit found;

  initial begin
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MULT / MULTU
    run(4'd1, 32'hFFFF_FFFF, 32'd2, nb, nd);
    check("mult busy cycles", nb, 5);
    check("mult done pulses", nd, 1);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFFE);
    run(4'd2, 32'hFFFF_FFFF, 32'd2, nb, nd);
    check("multu hi", hi, 32'h0000_0001);
    check("multu lo", lo, 32'hFFFF_FFFE);

    // DIV signed, including the overflow case
    run(4'd3, 32'hFFFF_FFF9, 32'd2, nb, nd);
    check("div busy cycles", nb, 10);
    check("div done pulses", nd, 1);
    check("div lo", lo, 32'hFFFF_FFFD);
    check("div hi", hi, 32'hFFFF_FFFF);
    run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd);
    check("div ovf lo", lo, 32'h8000_0000);
    check("div ovf hi", hi, 32'h0000_0000);

    // Divide by zero keeps HI/LO but takes full latency
    run(4'd5, 32'h11, 32'd0, nb, nd);
    check("mthi busy", nb, 0);
    check("mthi done", nd, 0);
    run(4'd6, 32'h22, 32'd0, nb, nd);
    run(4'd4, 32'd1234, 32'd0, nb, nd);
    check("divz busy cycles", nb, 10);
    check("divz done pulses", nd, 1);
    check("divz hi", hi, 32'h11);
    check("divz lo", lo, 32'h22);

    // Unassigned code has no effect
    run(4'd12, 32'd9, 32'd9, nb, nd);
    check("nop busy", nb, 0);
    check("nop hi", hi, 32'h11);

    // Back-to-back: MULT then DIV in the first non-busy cycle
    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'd1; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;
    found = 0;
    for (int i = 0; i < Window && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL b2b wait: busy never dropped within %0d cycles", Window);
    end
    check("b2b mult lo", lo, 32'd12);
    op_valid = 1'b1; op = 4'd4; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;
    @(negedge clk);
    check("b2b accept", 32'(busy), 32'd1);
    repeat (Window) @(negedge clk);
    check("b2b div lo", lo, 32'd14);
    check("b2b div hi", hi, 32'd2);

    // Cancel blocks acceptance
    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'd1; src_a = 32'd5; src_b = 32'd5; cancel = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0; cancel = 1'b0;
    nb = 0;
    repeat (4) begin @(negedge clk); if (busy) nb++; end
    check("cancel busy", nb, 0);
    check("cancel lo", lo, 32'd14);

    // Cancel during busy does not affect the in-flight op
    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'd1; src_a = 32'd6; src_b = 32'd7;
    @(posedge clk); #1;
    op = 4'd3; cancel = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0; cancel = 1'b0;
    repeat (Window) @(negedge clk);
    check("cancel busy lo", lo, 32'd42);
    check("cancel busy hi", hi, 32'd0);

    // MADDU: enabled -> accumulates; disabled -> no effect
    run(4'd5, 32'h0, 32'd0, nb, nd);
    run(4'd6, 32'hFFFF_FFFF, 32'd0, nb, nd);
`ifdef MDU_MADD_EN
    exp_nb = 5; exp_hi = 32'h1; exp_lo = 32'h0;
`else
    exp_nb = 0; exp_hi = 32'h0; exp_lo = 32'hFFFF_FFFF;
`endif
    run(4'd8, 32'd1, 32'd1, nb, nd);
    check("maddu busy", nb, exp_nb);
    check("maddu hi", hi, exp_hi);
    check("maddu lo", lo, exp_lo);

    // Reset mid-DIV aborts immediately
    run(4'd5, 32'h55, 32'd0, nb, nd);
    @(posedge clk); #1;
    op_valid = 1'b1; op = 4'd3; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (Window) begin @(negedge clk); if (done) nd++; end
    check("rst no done", nd, 0);
    check("rst hi after", hi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
